// File: rtl/video_timing_monitor.sv
// Purpose: measures line/frame timing of a sync/de stream and reports lock and timing errors.
// Latency: measurements, meas_valid and timing_err update 2 clk after the vsync leading edge is presented.
// Backpressure: none; free-running monitor that never stalls the video source.
module video_timing_monitor #(
    parameter int HS_POL      = 1,
    parameter int VS_POL      = 1,
    parameter int LOCK_FRAMES = 2,
    parameter int FCLK_W      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              de,
    output logic [15:0]       h_total,
    output logic [15:0]       h_active,
    output logic [15:0]       v_total,
    output logic [15:0]       v_active,
    output logic [FCLK_W-1:0] frame_clks,
    output logic              meas_valid,
    output logic              locked,
    output logic              timing_err
);

    localparam logic       HS_ACT = (HS_POL != 0);
    localparam logic       VS_ACT = (VS_POL != 0);
    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, FIRST, TRACK, LOCK} state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    // normalised (1 = active) registered inputs and their previous values
    logic hs_r, hs_p, vs_r, vs_p, de_r;
    logic hs_edge, vs_edge;

    logic [15:0]       hcnt, dcnt;
    logic [15:0]       lcnt, dlcnt, lcnt_nx, dlcnt_nx;
    logic [FCLK_W-1:0] fcnt;
    logic              fcnt_sat;
    logic [15:0]       ref_h, ref_d;
    logic              ref_h_vld, ref_d_vld, line_bad;
    logic              line_mis, frame_bad, same;
    logic [15:0]       new_h, new_d;

    state_t     state;
    logic [3:0] match_cnt;

    assign hs_edge  = hs_r & ~hs_p;
    assign vs_edge  = vs_r & ~vs_p;
    assign fcnt_sat = &fcnt;

    // closing line (at hs_edge) disagrees with the frame's first line
    assign line_mis = hs_edge &&
                      ((ref_h_vld && (hcnt != ref_h)) ||
                       (ref_d_vld && (dcnt != 16'd0) && (dcnt != ref_d)));
    assign frame_bad = line_bad | line_mis;

    // a line closing on the same cycle as the frame start still belongs to the ending frame
    assign lcnt_nx  = hs_edge ? sat_inc16(lcnt) : lcnt;
    assign dlcnt_nx = (hs_edge && (dcnt != 16'd0)) ? sat_inc16(dlcnt) : dlcnt;

    // per-line values of the ending frame, taken from its first complete line
    always_comb begin
        new_h = ref_h;
        new_d = ref_d;
        if (!ref_h_vld) new_h = hs_edge ? hcnt : 16'd0;
        if (!ref_d_vld) new_d = (hs_edge && (dcnt != 16'd0)) ? dcnt : 16'd0;
    end

    assign same = (new_h == h_total) && (new_d == h_active) &&
                  (lcnt_nx == v_total) && (dlcnt_nx == v_active) &&
                  (fcnt == frame_clks) && !frame_bad;

    // register and polarity-normalise the sync/de inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_r <= 1'b0;
            hs_p <= 1'b0;
            vs_r <= 1'b0;
            vs_p <= 1'b0;
            de_r <= 1'b0;
        end else begin
            hs_r <= (hsync == HS_ACT);
            hs_p <= hs_r;
            vs_r <= (vsync == VS_ACT);
            vs_p <= vs_r;
            de_r <= de;
        end
    end

    // line counters: clocks and de clocks since the last line start
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= 16'd0;
            dcnt <= 16'd0;
        end else if (hs_edge) begin
            hcnt <= 16'd1;
            dcnt <= {15'd0, de_r};
        end else begin
            hcnt <= sat_inc16(hcnt);
            dcnt <= de_r ? sat_inc16(dcnt) : dcnt;
        end
    end

    // frame counters and first-line reference used for the per-line consistency check
    always_ff @(posedge clk) begin
        if (rst) begin
            lcnt      <= 16'd0;
            dlcnt     <= 16'd0;
            fcnt      <= '0;
            ref_h     <= 16'd0;
            ref_d     <= 16'd0;
            ref_h_vld <= 1'b0;
            ref_d_vld <= 1'b0;
            line_bad  <= 1'b0;
        end else if (vs_edge) begin
            lcnt      <= 16'd0;
            dlcnt     <= 16'd0;
            fcnt      <= FCLK_W'(1);
            ref_h_vld <= 1'b0;
            ref_d_vld <= 1'b0;
            line_bad  <= 1'b0;
        end else begin
            lcnt  <= lcnt_nx;
            dlcnt <= dlcnt_nx;
            fcnt  <= fcnt_sat ? fcnt : fcnt + FCLK_W'(1);
            if (hs_edge) begin
                if (!ref_h_vld) begin
                    ref_h     <= hcnt;
                    ref_h_vld <= 1'b1;
                end
                if (!ref_d_vld && (dcnt != 16'd0)) begin
                    ref_d     <= dcnt;
                    ref_d_vld <= 1'b1;
                end
                if (line_mis) line_bad <= 1'b1;
            end
        end
    end

    // lock FSM with registered measurement outputs and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEARCH;
            match_cnt  <= 4'd0;
            h_total    <= 16'd0;
            h_active   <= 16'd0;
            v_total    <= 16'd0;
            v_active   <= 16'd0;
            frame_clks <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            timing_err <= 1'b0;
            if (fcnt_sat && (state != SEARCH)) begin
                h_total    <= 16'd0;
                h_active   <= 16'd0;
                v_total    <= 16'd0;
                v_active   <= 16'd0;
                frame_clks <= '0;
                locked     <= 1'b0;
                timing_err <= 1'b1;
                match_cnt  <= 4'd0;
                state      <= SEARCH;
            end else if (vs_edge) begin
                case (state)
                    SEARCH: state <= FIRST;
                    FIRST: begin
                        h_total    <= new_h;
                        h_active   <= new_d;
                        v_total    <= lcnt_nx;
                        v_active   <= dlcnt_nx;
                        frame_clks <= fcnt;
                        meas_valid <= 1'b1;
                        match_cnt  <= 4'd0;
                        state      <= TRACK;
                    end
                    TRACK: begin
                        meas_valid <= 1'b1;
                        if (same) begin
                            match_cnt <= match_cnt + 4'd1;
                            if ((match_cnt + 4'd1) >= LOCK_N) begin
                                locked <= 1'b1;
                                state  <= LOCK;
                            end
                        end else begin
                            h_total    <= new_h;
                            h_active   <= new_d;
                            v_total    <= lcnt_nx;
                            v_active   <= dlcnt_nx;
                            frame_clks <= fcnt;
                            match_cnt  <= 4'd0;
                            timing_err <= 1'b1;
                        end
                    end
                    LOCK: begin
                        meas_valid <= 1'b1;
                        if (!same) begin
                            h_total    <= new_h;
                            h_active   <= new_d;
                            v_total    <= lcnt_nx;
                            v_active   <= dlcnt_nx;
                            frame_clks <= fcnt;
                            match_cnt  <= 4'd0;
                            timing_err <= 1'b1;
                            locked     <= 1'b0;
                            state      <= TRACK;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_video_timing_monitor.sv
// Directed bench: instance a uses default polarity/width, instance b sees inverted syncs with a 10-bit frame counter.
// Each frame call records the status pulses of both instances; checks follow each call.
// Frames are 10 lines; de on lines 0..7, cycles 2..17 of each line; vsync rises at vs_off in line 0.
module tb_video_timing_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, hsync, vsync, de;
    logic hsync_inv, vsync_inv;
    assign hsync_inv = ~hsync;
    assign vsync_inv = ~vsync;

    logic [15:0] a_ht, a_ha, a_vt, a_va, b_ht, b_ha, b_vt, b_va;
    logic [23:0] a_fc;
    logic [9:0]  b_fc;
    logic        a_mv, a_lk, a_te, b_mv, b_lk, b_te;

    video_timing_monitor u_a (
        .clk(clk), .rst(rst_a), .hsync(hsync), .vsync(vsync), .de(de),
        .h_total(a_ht), .h_active(a_ha), .v_total(a_vt), .v_active(a_va),
        .frame_clks(a_fc), .meas_valid(a_mv), .locked(a_lk), .timing_err(a_te)
    );

    video_timing_monitor #(.HS_POL(0), .VS_POL(0), .LOCK_FRAMES(2), .FCLK_W(10)) u_b (
        .clk(clk), .rst(rst_b), .hsync(hsync_inv), .vsync(vsync_inv), .de(de),
        .h_total(b_ht), .h_active(b_ha), .v_total(b_vt), .v_active(b_va),
        .frame_clks(b_fc), .meas_valid(b_mv), .locked(b_lk), .timing_err(b_te)
    );

    int tests = 0;
    int fails = 0;

    // snapshot of the last status pulse seen in the current window, per instance
    int          sa_n, sa_cyc, sb_n, sb_cyc;
    logic        sa_mv, sa_te, sa_lk, sb_mv, sb_te, sb_lk;
    logic [15:0] sa_ht, sa_ha, sa_vt, sa_va, sb_ht, sb_ha, sb_vt, sb_va;
    logic [23:0] sa_fc, sb_fc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_snap();
        sa_n = 0; sb_n = 0; sa_cyc = -1; sb_cyc = -1;
        sa_mv = 0; sa_te = 0; sa_lk = 0; sb_mv = 0; sb_te = 0; sb_lk = 0;
        sa_ht = 0; sa_ha = 0; sa_vt = 0; sa_va = 0; sa_fc = 0;
        sb_ht = 0; sb_ha = 0; sb_vt = 0; sb_va = 0; sb_fc = 0;
    endtask

    task automatic sample(input int idx);
        if (a_mv || a_te) begin
            sa_n++; sa_cyc = idx;
            sa_mv = a_mv; sa_te = a_te; sa_lk = a_lk;
            sa_ht = a_ht; sa_ha = a_ha; sa_vt = a_vt; sa_va = a_va; sa_fc = a_fc;
        end
        if (b_mv || b_te) begin
            sb_n++; sb_cyc = idx;
            sb_mv = b_mv; sb_te = b_te; sb_lk = b_lk;
            sb_ht = b_ht; sb_ha = b_ha; sb_vt = b_vt; sb_va = b_va; sb_fc = {14'd0, b_fc};
        end
    endtask

    // inputs are already driven; sample outputs at negedge, return just after the next posedge
    task automatic step(input int idx);
        @(negedge clk);
        sample(idx);
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int ht, input int vs_off, input int bad_line, input int rst_line);
        clear_snap();
        for (int ln = 0; ln < 10; ln++) begin
            for (int x = 0; x < ht; x++) begin
                hsync = (x < 2);
                de    = (ln < 8) && (x >= 2) && (x < ((ln == bad_line) ? 17 : 18));
                vsync = (ln < 3) && ((ln * ht + x) >= vs_off);
                rst_b = (ln == rst_line);
                step(ln * ht + x);
            end
        end
        rst_b = 1'b0;
    endtask

    task automatic lines_no_vsync(input int n);
        clear_snap();
        vsync = 1'b0;
        for (int ln = 0; ln < n; ln++) begin
            for (int x = 0; x < 20; x++) begin
                hsync = (x < 2);
                de    = (x >= 2) && (x < 18);
                step(ln * 20 + x);
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; hsync = 1'b0; vsync = 1'b0; de = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(0);
        rst_a = 1'b0; rst_b = 1'b0;
        for (int i = 0; i < 4; i++) step(0);

        chk("rst_h_total", a_ht, 0);
        chk("rst_h_active", a_ha, 0);
        chk("rst_v_total", a_vt, 0);
        chk("rst_v_active", a_va, 0);
        chk("rst_frame_clks", a_fc, 0);
        chk("rst_meas_valid", a_mv, 0);
        chk("rst_locked", a_lk, 0);
        chk("rst_timing_err", a_te, 0);
        chk("rst_b_locked", b_lk, 0);

        // c1: first vsync edge only enters FIRST
        frame(20, 5, -1, -1);
        chk("c1_a_pulses", sa_n, 0);
        chk("c1_b_pulses", sb_n, 0);

        // c2: first publication; instance b reset mid-frame afterwards
        frame(20, 5, -1, 4);
        chk("c2_a_pulses", sa_n, 1);
        chk("c2_a_mv", sa_mv, 1);
        chk("c2_a_te", sa_te, 0);
        chk("c2_a_h_total", sa_ht, 20);
        chk("c2_a_h_active", sa_ha, 16);
        chk("c2_a_v_total", sa_vt, 10);
        chk("c2_a_v_active", sa_va, 8);
        chk("c2_a_frame_clks", sa_fc, 200);
        chk("c2_a_locked", sa_lk, 0);
        chk("c2_a_latency", sa_cyc, 7);
        chk("c2_b_h_total", sb_ht, 20);
        chk("c2_b_h_active", sb_ha, 16);
        chk("c2_b_v_total", sb_vt, 10);
        chk("c2_b_v_active", sb_va, 8);
        chk("c2_b_frame_clks", sb_fc, 200);
        chk("c2_b_after_rst_outputs", b_ht, 0);

        frame(20, 5, -1, -1);
        chk("c3_a_mv", sa_mv, 1);
        chk("c3_a_locked", sa_lk, 0);
        chk("c3_b_pulses", sb_n, 0);

        // c4 content changes nothing; a locks, b publishes two edges after reset release
        frame(20, 5, -1, -1);
        chk("c4_a_locked", sa_lk, 1);
        chk("c4_a_te", sa_te, 0);
        chk("c4_b_pulses", sb_n, 1);
        chk("c4_b_mv", sb_mv, 1);
        chk("c4_b_frame_clks", sb_fc, 200);

        frame(20, 5, -1, -1);
        chk("c5_a_mv", sa_mv, 1);
        chk("c5_a_locked", sa_lk, 1);

        // c6 content has 22-clock lines
        frame(22, 5, -1, -1);
        chk("c6_b_locked", sb_lk, 1);

        frame(20, 5, -1, -1);
        chk("c7_a_te", sa_te, 1);
        chk("c7_a_mv", sa_mv, 1);
        chk("c7_a_h_total", sa_ht, 22);
        chk("c7_a_h_active", sa_ha, 16);
        chk("c7_a_v_total", sa_vt, 10);
        chk("c7_a_frame_clks", sa_fc, 220);
        chk("c7_a_locked", sa_lk, 0);
        chk("c7_b_te", sb_te, 1);

        frame(20, 5, -1, -1);
        chk("c8_a_te", sa_te, 1);
        chk("c8_a_h_total", sa_ht, 20);
        chk("c8_a_frame_clks", sa_fc, 200);

        frame(20, 5, -1, -1);
        chk("c9_a_te", sa_te, 0);
        chk("c9_a_locked", sa_lk, 0);

        // c10 content has one line with 15 de clocks
        frame(20, 5, 3, -1);
        chk("c10_a_locked", sa_lk, 1);
        chk("c10_b_locked", sb_lk, 1);

        frame(20, 5, -1, -1);
        chk("c11_a_te", sa_te, 1);
        chk("c11_a_mv", sa_mv, 1);
        chk("c11_a_locked", sa_lk, 0);
        chk("c11_a_h_active", sa_ha, 16);
        chk("c11_b_te", sb_te, 1);

        frame(20, 5, -1, -1);
        chk("c12_a_locked", sa_lk, 0);
        frame(20, 5, -1, -1);
        chk("c13_a_locked", sa_lk, 1);
        chk("c13_b_locked", sb_lk, 1);
        frame(20, 5, -1, -1);
        chk("c14_b_locked", sb_lk, 1);

        // vsync absent long enough to saturate b's frame counter but not a's
        lines_no_vsync(55);
        chk("to_a_pulses", sa_n, 0);
        chk("to_b_pulses", sb_n, 1);
        chk("to_b_te", sb_te, 1);
        chk("to_b_mv", sb_mv, 0);
        chk("to_b_h_total", sb_ht, 0);
        chk("to_b_h_active", sb_ha, 0);
        chk("to_b_v_total", sb_vt, 0);
        chk("to_b_v_active", sb_va, 0);
        chk("to_b_frame_clks", sb_fc, 0);
        chk("to_b_locked", sb_lk, 0);

        frame(20, 5, -1, -1);
        chk("c15_b_pulses", sb_n, 0);
        chk("c15_a_te", sa_te, 1);
        chk("c15_a_frame_clks", sa_fc, 1300);
        chk("c15_a_locked", sa_lk, 0);

        frame(20, 5, -1, -1);
        chk("c16_b_mv", sb_mv, 1);
        chk("c16_b_te", sb_te, 0);
        chk("c16_b_h_total", sb_ht, 20);
        chk("c16_b_frame_clks", sb_fc, 200);

        // coincident hsync/vsync edges
        frame(20, 0, -1, -1);
        chk("c17_a_te", sa_te, 1);
        chk("c17_a_frame_clks", sa_fc, 195);
        chk("c17_a_latency", sa_cyc, 2);

        frame(20, 0, -1, -1);
        chk("c18_a_mv", sa_mv, 1);
        chk("c18_a_h_total", sa_ht, 20);
        chk("c18_a_h_active", sa_ha, 16);
        chk("c18_a_v_total", sa_vt, 10);
        chk("c18_a_v_active", sa_va, 8);
        chk("c18_a_frame_clks", sa_fc, 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
